hms_bcd_counter: RTL and testbench

Time-of-day source for the 6-digit seven-segment display path. It divides the system clock down to a 1 Hz tick and keeps hours:minutes:seconds as six packed BCD digits. It accepts a validated time load and a minute-advance request. Its digit bus and update strobe feed the downstream segment/digit-select scanner directly.

---
 rtl/hms_pkg.sv | 48 ++++
 rtl/bcd_pair_cnt.sv | 46 ++++
 rtl/hms_bcd_counter.sv | 147 ++++++++++++++
 tb/tb_hms_bcd_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// Shared types, limits and BCD helpers for the hh:mm:ss time-of-day counter.
// Build option: define HOUR12_EN for 01..12 hours with an AM/PM flag.
package hms_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t h1;
      bcd_t h0;
      bcd_t m1;
      bcd_t m0;
      bcd_t s1;
      bcd_t s0;
   } time_t;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
`ifdef HOUR12_EN
   localparam int HR_MAX  = 12;
   localparam int HR_MIN  = 1;
   localparam int HR_RST  = 12;
`else
   localparam int HR_MAX  = 23;
   localparam int HR_MIN  = 0;
   localparam int HR_RST  = 0;
`endif

   // Two BCD digits to binary. Only meaningful for nibbles <= 9.
   function automatic logic [6:0] bcd_to_bin(input logic [7:0] pair);
      return 7'(pair[7:4]) * 7'd10 + 7'(pair[3:0]);
   endfunction

   // Binary 0..99 back to two BCD digits.
   function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
      bcd_t t;
      bcd_t o;
      t = 4'(v / 7'd10);
      o = 4'(v - 7'(t) * 7'd10);
      return {t, o};
   endfunction

   // Both nibbles are decimal digits and the pair value does not exceed max.
   function automatic logic bcd_pair_valid(input logic [7:0] pair, input int max);
      return (pair[7:4] <= 4'd9) && (pair[3:0] <= 4'd9) &&
             (bcd_to_bin(pair) <= 7'(max));
   endfunction

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD counter over MIN..MAX. Steps by i_inc (0..2) per clock,
// wrapping past MAX back to MIN and flagging the wrap on o_carry.
// A load overrides any step.
module bcd_pair_cnt
   import hms_pkg::*;
#(
   parameter int MAX = 59,
   parameter int MIN = 0,
   parameter int RST = 0
) (
   input  logic       i_ck,
   input  logic       i_reset_n,
   input  logic [1:0] i_inc,
   input  logic       i_load,
   input  logic [7:0] i_ld,
   output logic [7:0] o_pair,
   output logic       o_carry
);

   logic [7:0] r_pair;
   logic [7:0] w_sum;
   logic [7:0] w_wrap;
   logic [7:0] w_nxt;

   // Next value in binary: add the step, fold back into MIN..MAX on overflow.
   always_comb begin
      w_sum   = {1'b0, bcd_to_bin(r_pair)} + {6'd0, i_inc};
      w_wrap  = w_sum - 8'(MAX - MIN + 1);
      o_carry = (w_sum > 8'(MAX));
      w_nxt   = bin_to_bcd(7'(o_carry ? w_wrap : w_sum));
   end

   // Pair register: load wins, otherwise advance when a step is requested.
   always_ff @(posedge i_ck or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pair <= bin_to_bcd(7'(RST));
      end else if (i_load) begin
         r_pair <= i_ld;
      end else if (i_inc != 2'd0) begin
         r_pair <= w_nxt;
      end
   end

   assign o_pair = r_pair;

endmodule

// File: rtl/hms_bcd_counter.sv
// Time-of-day source for the seven-segment scanner: divides ck to a 1 Hz
// tick and keeps hh:mm:ss as six packed BCD digits, with validated load and
// minute-advance. All outputs are registered; digits, upd and sec_tick move
// on the same edge.
// Build option: HOUR12_EN selects 01..12 hours and adds the pm output.
module hms_bcd_counter
   import hms_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic        ck,
   input  logic        reset,
   input  logic        en,
   input  logic        load,
   input  logic [23:0] ld_time,
   input  logic        inc_min,
   output logic [23:0] digits,
   output logic        sec_tick,
   output logic        upd,
`ifdef HOUR12_EN
   output logic        pm,
`endif
   output logic        load_err
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_presc;
   logic             r_sec_tick;
   logic             r_upd;
   logic             r_load_err;

   time_t            w_ld;
   logic [7:0]       w_ld_hr;
   logic             w_ld_valid;
   logic             w_ld_ok;
   logic             w_tick;
   logic [1:0]       w_sec_step;
   logic [1:0]       w_min_step;
   logic [1:0]       w_hr_step;
   logic             w_sec_cy;
   logic             w_min_cy;
   logic             w_hr_cy;
   logic [7:0]       w_sec;
   logic [7:0]       w_min;
   logic [7:0]       w_hr;

   assign w_ld = time_t'(ld_time);

`ifdef HOUR12_EN
   logic r_pm;
   // In 12-hour mode bit 23 carries pm and only bit 20 of h1 is meaningful.
   assign w_ld_hr    = {3'b000, ld_time[20], w_ld.h0};
   assign w_ld_valid = bcd_pair_valid(w_ld_hr, HR_MAX) && (w_ld_hr != 8'h00) &&
                       bcd_pair_valid({w_ld.m1, w_ld.m0}, MIN_MAX) &&
                       bcd_pair_valid({w_ld.s1, w_ld.s0}, SEC_MAX);
`else
   assign w_ld_hr    = {w_ld.h1, w_ld.h0};
   assign w_ld_valid = bcd_pair_valid(w_ld_hr, HR_MAX) &&
                       bcd_pair_valid({w_ld.m1, w_ld.m0}, MIN_MAX) &&
                       bcd_pair_valid({w_ld.s1, w_ld.s0}, SEC_MAX);
`endif

   // A second elapses on the edge that wraps the prescaler. The seconds
   // carry and inc_min both feed the minute stage, so a coincident tick and
   // minute-advance steps minutes by two (second first, then one minute).
   assign w_ld_ok    = load && w_ld_valid;
   assign w_tick     = en && (r_presc == LP_LAST);
   assign w_sec_step = {1'b0, w_tick};
   assign w_min_step = {1'b0, w_sec_cy} + {1'b0, inc_min};
   assign w_hr_step  = {1'b0, w_min_cy};

   bcd_pair_cnt #(.MAX(SEC_MAX), .MIN(0), .RST(0)) u_sec (
      .i_ck      (ck),
      .i_reset_n (reset),
      .i_inc     (w_sec_step),
      .i_load    (w_ld_ok),
      .i_ld      ({w_ld.s1, w_ld.s0}),
      .o_pair    (w_sec),
      .o_carry   (w_sec_cy)
   );

   bcd_pair_cnt #(.MAX(MIN_MAX), .MIN(0), .RST(0)) u_min (
      .i_ck      (ck),
      .i_reset_n (reset),
      .i_inc     (w_min_step),
      .i_load    (w_ld_ok),
      .i_ld      ({w_ld.m1, w_ld.m0}),
      .o_pair    (w_min),
      .o_carry   (w_min_cy)
   );

   bcd_pair_cnt #(.MAX(HR_MAX), .MIN(HR_MIN), .RST(HR_RST)) u_hr (
      .i_ck      (ck),
      .i_reset_n (reset),
      .i_inc     (w_hr_step),
      .i_load    (w_ld_ok),
      .i_ld      (w_ld_hr),
      .o_pair    (w_hr),
      .o_carry   (w_hr_cy)
   );

   // Prescaler: a valid load restarts the second; otherwise count while enabled.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
      end else if (w_ld_ok) begin
         r_presc <= '0;
      end else if (en) begin
         r_presc <= (r_presc == LP_LAST) ? '0 : r_presc + 1'b1;
      end
   end

   // Strobes: any stage that moves (or any valid load) changes the digits.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_sec_tick <= 1'b0;
         r_upd      <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_sec_tick <= w_tick && !w_ld_ok;
         r_upd      <= w_ld_ok || w_tick || (w_min_step != 2'd0) || w_hr_cy;
         r_load_err <= load && !w_ld_valid;
      end
   end

`ifdef HOUR12_EN
   // AM/PM flips when hours step from 11 to 12; a valid load sets it directly.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_pm <= 1'b0;
      end else if (w_ld_ok) begin
         r_pm <= ld_time[23];
      end else if (w_min_cy && (w_hr == 8'h11)) begin
         r_pm <= ~r_pm;
      end
   end
   assign pm = r_pm;
`endif

   assign digits   = {w_hr, w_min, w_sec};
   assign sec_tick = r_sec_tick;
   assign upd      = r_upd;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_hms_bcd_counter.sv
// Bench for hms_bcd_counter (24-hour build, TICK_DIV=4). The reference keeps
// time as seconds-of-day and the prescaler as a plain integer.
module tb_hms_bcd_counter;

   localparam int TD = 4;

   logic        ck = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [23:0] ld_time = 24'h0;
   logic        inc_min = 1'b0;
   logic [23:0] digits;
   logic        sec_tick;
   logic        upd;
   logic        load_err;

   int n_total = 0;
   int n_bad = 0;
   logic chk_on = 1'b0;

   // clock / reset
   always #5 ck = ~ck;

   hms_bcd_counter #(.TICK_DIV(TD), .CNT_W(3)) dut (
      .ck       (ck),
      .reset    (reset),
      .en       (en),
      .load     (load),
      .ld_time  (ld_time),
      .inc_min  (inc_min),
      .digits   (digits),
      .sec_tick (sec_tick),
      .upd      (upd),
      .load_err (load_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference helpers
   function automatic logic time_ok(input logic [23:0] v);
      int h;
      h = int'(v[23:20]) * 10 + int'(v[19:16]);
      return (v[23:20] <= 9) && (v[19:16] <= 9) && (v[15:12] <= 5) && (v[11:8] <= 9) &&
             (v[7:4] <= 5) && (v[3:0] <= 9) && (h <= 23);
   endfunction

   function automatic int to_secs(input logic [23:0] v);
      return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
             (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
             (int'(v[7:4]) * 10 + int'(v[3:0]));
   endfunction

   function automatic logic [23:0] enc(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   // reference model: seconds-of-day plus prescaler count
   int   m_t;
   int   m_pc;
   logic exp_tick;
   logic exp_upd;
   logic exp_err;

   always @(posedge ck or negedge reset) begin
      int   nt;
      logic tk;
      if (!reset) begin
         m_t = 0; m_pc = 0; exp_tick = 1'b0; exp_upd = 1'b0; exp_err = 1'b0;
      end else begin
         tk = en && (m_pc == TD - 1);
         if (load && time_ok(ld_time)) begin
            m_t = to_secs(ld_time); m_pc = 0;
            exp_tick = 1'b0; exp_upd = 1'b1; exp_err = 1'b0;
         end else begin
            exp_err = load;
            if (en) m_pc = (m_pc + 1) % TD;
            exp_tick = tk;
            nt = (m_t + (tk ? 1 : 0)) % 86400;
            if (inc_min) nt = (nt + 60) % 86400;
            exp_upd = (nt != m_t);
            m_t = nt;
         end
      end
   end

   // scoreboard compare, every cycle, away from the active edge
   always @(negedge ck) begin
      if (chk_on) begin
         chk("digits", 32'(digits), 32'(enc(m_t)));
         chk("sec_tick", 32'(sec_tick), 32'(exp_tick));
         chk("upd", 32'(upd), 32'(exp_upd));
         chk("load_err", 32'(load_err), 32'(exp_err));
      end
   end

   // driver
   task automatic step(input logic l, input logic [23:0] t, input logic im);
      @(negedge ck);
      load = l; ld_time = t; inc_min = im;
      @(posedge ck);
      #1;
   endtask

   initial begin
      logic [23:0] rt;
      repeat (3) @(posedge ck);
      #1;
      chk("rst_digits", 32'(digits), 32'h0);
      chk("rst_sec_tick", 32'(sec_tick), 32'h0);
      chk("rst_upd", 32'(upd), 32'h0);
      chk("rst_load_err", 32'(load_err), 32'h0);
      chk_on = 1'b1;
      reset = 1'b1;
      en = 1'b1;

      // free run: one tick every 4th cycle
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 24'h0, 1'b0);
         chk("tick_cadence", 32'(sec_tick), 32'((i % 4) == 0));
         if (i == 4) chk("first_sec", 32'(digits), 32'h000001);
      end
      chk("three_secs", 32'(digits), 32'h000003);

      // midnight rollover
      step(1'b1, 24'h235958, 1'b0);
      chk("load_val", 32'(digits), 32'h235958);
      chk("load_upd", 32'(upd), 32'h1);
      repeat (4) step(1'b0, 24'h0, 1'b0);
      chk("pre_midnight", 32'(digits), 32'h235959);
      repeat (4) step(1'b0, 24'h0, 1'b0);
      chk("midnight", 32'(digits), 32'h000000);
      chk("midnight_upd", 32'(upd), 32'h1);

      // rejected loads; prescaler keeps running
      step(1'b1, 24'h240000, 1'b0);
      chk("bad_hour_err", 32'(load_err), 32'h1);
      step(1'b1, 24'h126000, 1'b0);
      chk("bad_min_err", 32'(load_err), 32'h1);
      chk("bad_load_hold", 32'(digits), 32'h000000);
      step(1'b0, 24'h0, 1'b0);
      chk("err_one_cycle", 32'(load_err), 32'h0);
      step(1'b0, 24'h0, 1'b0);
      chk("presc_kept", 32'(digits), 32'h000001);

      // tick and minute-advance on the same edge: second first, then a minute
      step(1'b1, 24'h105959, 1'b0);
      repeat (3) step(1'b0, 24'h0, 1'b0);
      step(1'b0, 24'h0, 1'b1);
      chk("tick_plus_min", 32'(digits), 32'h110100);

      // minute-advance while disabled
      en = 1'b0;
      step(1'b1, 24'h235930, 1'b0);
      step(1'b0, 24'h0, 1'b1);
      chk("inc_min_frozen", 32'(digits), 32'h000030);
      repeat (5) step(1'b0, 24'h0, 1'b0);
      chk("frozen_hold", 32'(digits), 32'h000030);

      // load on the prescaler wrap cycle
      en = 1'b1;
      step(1'b1, 24'h081459, 1'b0);
      repeat (3) step(1'b0, 24'h0, 1'b0);
      step(1'b1, 24'h081500, 1'b0);
      chk("wrap_load_notick", 32'(sec_tick), 32'h0);
      chk("wrap_load_val", 32'(digits), 32'h081500);
      repeat (3) step(1'b0, 24'h0, 1'b0);
      chk("wrap_load_hold", 32'(digits), 32'h081500);
      step(1'b0, 24'h0, 1'b0);
      chk("wrap_load_next", 32'(digits), 32'h081501);

      // reset mid-count restarts the full period
      repeat (2) step(1'b0, 24'h0, 1'b0);
      reset = 1'b0;
      #2;
      chk("async_rst", 32'(digits), 32'h0);
      reset = 1'b1;
      repeat (3) step(1'b0, 24'h0, 1'b0);
      chk("rst_restart_hold", 32'(digits), 32'h0);
      step(1'b0, 24'h0, 1'b0);
      chk("rst_restart_tick", 32'(digits), 32'h000001);

      // randomized traffic against the reference
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 1) == 0) rt = enc(int'($urandom_range(0, 86399)));
         else rt = 24'($urandom());
         step($urandom_range(0, 19) == 0, rt, $urandom_range(0, 19) == 0);
      end

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
